// File: rtl/shift_unit_arbiter.sv
// Round-robin front end that shares one 16-bit barrel left shifter among NREQ
// requesters. Results go to a credit-protected FIFO, tagged with id and overflow.

module barrel_leftshifter_16bit (
  input  logic [15:0] i_data,
  input  logic [3:0]  i_amt,
  output logic [15:0] o_data
);
  logic [15:0] w_st0, w_st1, w_st2;

  assign w_st0  = i_amt[0] ? {i_data[14:0], 1'b0}  : i_data;
  assign w_st1  = i_amt[1] ? {w_st0[13:0], 2'b0}   : w_st0;
  assign w_st2  = i_amt[2] ? {w_st1[11:0], 4'b0}   : w_st1;
  assign o_data = i_amt[3] ? {w_st2[7:0],  8'b0}   : w_st2;
endmodule

module shift_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_data,
  input  logic [NREQ*4-1:0]    req_amt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_ovf,
  output logic                 busy
);
  localparam int CW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0]    data;
    logic [IDW-1:0] id;
    logic           ovf;
  } entry_t;

  logic [IDW-1:0] r_ptr;
  logic           r_s1_valid;
  logic [15:0]    r_s1_data;
  logic [3:0]     r_s1_amt;
  logic [IDW-1:0] r_s1_id;

  entry_t         r_mem [DEPTH];
  logic [CW-1:0]  r_wr, r_rd;
  logic [CW:0]    r_count;

  logic           w_pop, w_accept_ok, w_found, w_accept;
  logic [IDW-1:0] w_winner;
  logic [CW+1:0]  w_occ;
  logic [15:0]    w_shifted, w_ovf_mask;
  logic           w_ovf;
  entry_t         w_head;

  assign rsp_valid = (r_count != '0);
  assign w_pop     = rsp_valid & rsp_ready;

  // Entries owed a FIFO slot: queued results plus the one in the operand stage.
  assign w_occ       = {1'b0, r_count} + {{(CW+1){1'b0}}, r_s1_valid};
  assign w_accept_ok = rst_n & ((w_occ < (CW+2)'(DEPTH)) | w_pop);

  always_comb begin
    logic [IDW-1:0] v_idx;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      v_idx = r_ptr + IDW'(i);
      if (!w_found && req_valid[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end
    end
  end

  assign w_accept  = w_found & w_accept_ok;
  assign req_ready = w_accept ? (NREQ'(1) << w_winner) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_amt   <= '0;
      r_s1_id    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_ptr     <= w_winner + IDW'(1);
        r_s1_data <= req_data[{w_winner, 4'b0} +: 16];
        r_s1_amt  <= req_amt[{w_winner, 2'b0} +: 4];
        r_s1_id   <= w_winner;
      end
    end
  end

  barrel_leftshifter_16bit u_shifter (
    .i_data (r_s1_data),
    .i_amt  (r_s1_amt),
    .o_data (w_shifted)
  );

  // Bits that fall off the top are exactly the top amt bits of the operand.
  assign w_ovf_mask = ~(16'hFFFF >> r_s1_amt);
  assign w_ovf      = |(r_s1_data & w_ovf_mask);

  // NOTE: storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (r_s1_valid) r_mem[r_wr] <= '{data: w_shifted, id: r_s1_id, ovf: w_ovf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (r_s1_valid) r_wr <= r_wr + CW'(1);
      if (w_pop)      r_rd <= r_rd + CW'(1);
      case ({r_s1_valid, w_pop})
        2'b10:   r_count <= r_count + (CW+1)'(1);
        2'b01:   r_count <= r_count - (CW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head   = r_mem[r_rd];
  assign rsp_data = rsp_valid ? w_head.data : '0;
  assign rsp_id   = rsp_valid ? w_head.id   : '0;
  assign rsp_ovf  = rsp_valid & w_head.ovf;
  assign busy     = r_s1_valid | rsp_valid;
endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one barrel_leftshifter_16bit (logical left shift, 4-bit amount) among NREQ requesters.
- Each requester posts a 16-bit operand and a shift amount on a valid/ready handshake. The block grants one request per cycle, round-robin.
- The accepted operand is registered into an operand stage, shifted, and queued in an output FIFO. Results are returned tagged with the requester id and an overflow flag.
- Sits between the datapath clients and the shifter; it is the only instantiator of the shifter in the shift unit.

Parameters:
- NREQ, 4, number of requesters; must equal 2**IDW.
- IDW, 2, width of requester id.
- DEPTH, 4, output FIFO entries (>=2, power of two).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  request valid, one bit per requester.
- req_ready  output  NREQ  grant/accept, one bit per requester.
- req_data  input  NREQ*16  operands; requester i uses bits [16i+15:16i].
- req_amt  input  NREQ*4  shift amounts; requester i uses bits [4i+3:4i].
- rsp_valid  output  1  FIFO head valid.
- rsp_ready  input  1  consumer accepts head.
- rsp_data  output  16  shifted result.
- rsp_id  output  IDW  requester index of result.
- rsp_ovf  output  1  set when any nonzero bit was shifted out.
- busy  output  1  operand stage valid or FIFO non-empty.

Behaviour:
- Reset (asynchronous, rst_n low):
  - RR pointer = 0, operand stage invalid, FIFO count = 0.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_ovf = 0, busy = 0, req_ready = 0.
  - In-flight requests and queued results are dropped; no response is ever produced for them.
- Credit:
  - pop = rsp_valid & rsp_ready.
  - free = DEPTH - count - s1_valid + pop.
  - Accept is allowed only when free > 0.
- Arbitration (combinational, same cycle):
  - Search req_valid starting at the RR pointer, wrapping modulo NREQ; the first set bit wins.
  - req_ready[winner] = 1 iff accept is allowed; all other req_ready bits = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - Once asserted, req_valid and its operands stay stable until accepted.
- On accept at edge N:
  - The operand stage captures {data, amt, id}; s1_valid = 1.
  - RR pointer = winner + 1 (mod NREQ).
  - No accept: pointer unchanged.
- Edge N+1:
  - If s1_valid, push {shift(data, amt), id, ovf} into the FIFO.
  - s1_valid follows the accept at N+1.
  - rsp_valid is first high after edge N+1 (latency 2 cycles from accept to visibility), one per accept, with no bubbles at full rate.
- Shift and overflow:
  - result = (data << amt) truncated to 16 bits, computed by the shifter instance.
  - ovf = OR of data bits [15 : 16-amt]; amt = 0 gives passthrough with ovf = 0.
- FIFO:
  - rsp_* are driven from the head entry; when empty they are 0.
  - Push and pop in the same cycle leave count unchanged; read/write pointers wrap modulo DEPTH.
  - Push never occurs when the FIFO is full without a pop; the credit rule guarantees this.
  - Results return in acceptance order.
- Throughput: one accept per cycle sustained while rsp_ready = 1.
- busy = s1_valid | (count != 0).

Test Plan:
- Single request: req 0, data 0x00F3, amt 4, rsp_ready = 1 -> req_ready[0] high the same cycle. Two edges later rsp_valid = 1, rsp_data = 0x0F30, rsp_id = 0, rsp_ovf = 0, held for exactly one cycle.
- Overflow and boundaries, one at a time:
  - data 0x0003, amt 15 -> 0x8000, ovf 1.
  - data 0x8001, amt 1 -> 0x0002, ovf 1.
  - data 0xABCD, amt 0 -> 0xABCD, ovf 0.
  - data 0x0001, amt 15 -> 0x8000, ovf 0.
- Fairness: all 4 req_valid held high for 8 cycles, rsp_ready = 1 -> grant order 0,1,2,3,0,1,2,3. The rsp_id sequence matches, with no idle cycles.
- Backpressure: rsp_ready = 0 with all requesters active:
  - Exactly DEPTH accepts total, then req_ready stays 0.
  - Raise rsp_ready -> FIFO drains in order, accepts resume one per cycle, no entry lost or duplicated.
- Full with simultaneous pop: FIFO holding DEPTH-1 entries, s1_valid = 1, rsp_ready = 1 -> a new accept is granted the same cycle and count stays constant.
- Reset mid-operation: assert rst_n low with 3 entries queued and s1_valid = 1 -> outputs are 0 immediately (asynchronously). After release, no stale responses appear and the first grant goes to requester 0.
